// File: rtl/control_memory_pkg.sv
// Shared types and helpers for the multithreaded control memory.
// Address layout is {thread, opcode} with the thread in the MSBs.
package control_memory_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } cm_state_e;

    localparam int CM_LAT_MIN = 1;
    localparam int CM_LAT_MAX = 2;

    function automatic int cm_addr_width(input int opcode_w, input int thread_w);
        return opcode_w + thread_w;
    endfunction

    function automatic int cm_depth(input int thread_cnt, input int opcode_w);
        return thread_cnt * (1 << opcode_w);
    endfunction

    function automatic bit cm_latency_legal(input int lat);
        return (lat >= CM_LAT_MIN) && (lat <= CM_LAT_MAX);
    endfunction

endpackage

// File: rtl/control_memory_thread_counter.sv
// Round-robin hardware thread counter, wraps COUNT-1 -> 0.
// Runs every cycle regardless of the memory's init/run state.
module control_memory_thread_counter
    import control_memory_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [WIDTH-1:0] thread
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thread <= '0;
        end else if (thread == LAST) begin
            thread <= '0;
        end else begin
            thread <= thread + WIDTH'(1);
        end
    end

endmodule

// File: rtl/control_memory_mt.sv
// Multithreaded opcode-to-control-word RAM with self-initialisation,
// write/read collision forwarding and thread-tagged read output.
module control_memory_mt
    import control_memory_pkg::*;
#(
    parameter int                        OPCODE_WIDTH       = 4,
    parameter int                        CONTROL_WIDTH      = 20,
    parameter int                        THREAD_COUNT       = 8,
    parameter int                        THREAD_COUNT_WIDTH = 3,
    parameter int                        READ_LATENCY       = 1,
    parameter int                        READ_NEW_DATA      = 0,
    parameter logic [CONTROL_WIDTH-1:0]  DEFAULT_CONTROL    = '0,
    parameter string                     RAMSTYLE           = ""
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wren,
    input  logic [THREAD_COUNT_WIDTH-1:0] write_thread,
    input  logic [OPCODE_WIDTH-1:0]       write_addr,
    input  logic [CONTROL_WIDTH-1:0]      write_data,
    input  logic                          rden,
    input  logic [OPCODE_WIDTH-1:0]       read_addr,
    output logic [CONTROL_WIDTH-1:0]      read_data,
    output logic                          read_valid,
    output logic [THREAD_COUNT_WIDTH-1:0] read_thread,
    output logic                          ready,
    output logic                          write_dropped
);

    localparam int CM_ADDR_WIDTH = cm_addr_width(OPCODE_WIDTH, THREAD_COUNT_WIDTH);
    localparam int CM_DEPTH      = cm_depth(THREAD_COUNT, OPCODE_WIDTH);
    localparam int IW            = CM_ADDR_WIDTH + 1;

    localparam logic [IW-1:0] INIT_LAST = IW'(CM_DEPTH - 1);
    localparam logic [THREAD_COUNT_WIDTH-1:0] THREAD_LAST =
        THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

    if (!cm_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    cm_state_e state, state_d;
    logic [IW-1:0] init_addr, init_addr_d;
    logic [THREAD_COUNT_WIDTH-1:0] current_thread;

    control_memory_thread_counter #(
        .COUNT (THREAD_COUNT),
        .WIDTH (THREAD_COUNT_WIDTH)
    ) u_thread_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .thread  (current_thread)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_d;
            init_addr <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state;
        init_addr_d = init_addr;
        unique case (state)
            INIT: begin
                init_addr_d = init_addr + IW'(1);
                if (init_addr == INIT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ready = (state == RUN);

    (* ramstyle = RAMSTYLE *)
    logic [CONTROL_WIDTH-1:0] mem [CM_DEPTH];

    logic                     thread_ok;
    logic                     ram_we;
    logic [CM_ADDR_WIDTH-1:0] ram_waddr;
    logic [CONTROL_WIDTH-1:0] ram_wdata;
    logic [CM_ADDR_WIDTH-1:0] ram_raddr;
    logic                     rd_fire;
    logic                     rd_fwd;
    logic [CONTROL_WIDTH-1:0] rd_word;

    assign thread_ok = (write_thread <= THREAD_LAST);

    // During INIT the write port belongs to the default-word sweep.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {write_thread, write_addr};
        ram_wdata = write_data;
        if (!ready) begin
            ram_we    = 1'b1;
            ram_waddr = init_addr[CM_ADDR_WIDTH-1:0];
            ram_wdata = DEFAULT_CONTROL;
        end else if (wren && thread_ok) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign ram_raddr = {current_thread, read_addr};
    assign rd_fire   = rden && ready;
    assign rd_fwd    = (READ_NEW_DATA != 0) && ram_we && (ram_waddr == ram_raddr);
    assign rd_word   = rd_fwd ? write_data : mem[ram_raddr];

    logic [CONTROL_WIDTH-1:0]      s1_data;
    logic                          s1_valid;
    logic [THREAD_COUNT_WIDTH-1:0] s1_thread;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_data       <= '0;
            s1_valid      <= 1'b0;
            s1_thread     <= '0;
            write_dropped <= 1'b0;
        end else begin
            s1_valid      <= rd_fire;
            write_dropped <= wren && (!ready || !thread_ok);
            if (rd_fire) begin
                s1_data   <= rd_word;
                s1_thread <= current_thread;
            end
        end
    end

    if (READ_LATENCY >= 2) begin : g_lat2
        logic [CONTROL_WIDTH-1:0]      s2_data;
        logic                          s2_valid;
        logic [THREAD_COUNT_WIDTH-1:0] s2_thread;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_data   <= '0;
                s2_valid  <= 1'b0;
                s2_thread <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data   <= s1_data;
                    s2_thread <= s1_thread;
                end
            end
        end

        assign read_data   = s2_data;
        assign read_valid  = s2_valid;
        assign read_thread = s2_thread;
    end else begin : g_lat1
        assign read_data   = s1_data;
        assign read_valid  = s1_valid;
        assign read_thread = s1_thread;
    end

endmodule

// File: tb/tb_control_memory_mt.sv
// Scoreboard bench: three control memory configurations share one stimulus
// stream; a negedge monitor pops expected reads as read_valid appears.
module tb_control_memory_mt;

    localparam int N = 3;

    typedef struct {
        logic [19:0] data;
        logic [2:0]  thr;
        int          due;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        wren;
    logic [2:0]  write_thread;
    logic [3:0]  write_addr;
    logic [19:0] write_data;
    logic        rden;
    logic [3:0]  read_addr;

    logic [19:0] rd   [N];
    logic        rv   [N];
    logic [2:0]  rt   [N];
    logic        rdy  [N];
    logic        drop [N];

    int total = 0;
    int bad   = 0;
    int ec;

    exp_t        sbq [N][$];
    logic [19:0] mem [N][128];

    function automatic int tc_of(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic bit new_of(input int k);
        return (k == 1);
    endfunction

    function automatic int dep_of(input int k);
        return tc_of(k) * 16;
    endfunction

    control_memory_mt #(
        .THREAD_COUNT(8), .READ_LATENCY(1), .READ_NEW_DATA(0),
        .DEFAULT_CONTROL(20'h00001)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .wren(wren),
        .write_thread(write_thread), .write_addr(write_addr),
        .write_data(write_data), .rden(rden), .read_addr(read_addr),
        .read_data(rd[0]), .read_valid(rv[0]), .read_thread(rt[0]),
        .ready(rdy[0]), .write_dropped(drop[0])
    );

    control_memory_mt #(
        .THREAD_COUNT(8), .READ_LATENCY(2), .READ_NEW_DATA(1),
        .DEFAULT_CONTROL(20'h00001)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .wren(wren),
        .write_thread(write_thread), .write_addr(write_addr),
        .write_data(write_data), .rden(rden), .read_addr(read_addr),
        .read_data(rd[1]), .read_valid(rv[1]), .read_thread(rt[1]),
        .ready(rdy[1]), .write_dropped(drop[1])
    );

    control_memory_mt #(
        .THREAD_COUNT(6), .READ_LATENCY(1), .READ_NEW_DATA(0),
        .DEFAULT_CONTROL(20'h00001)
    ) u_c (
        .clock(clock), .reset_n(reset_n), .wren(wren),
        .write_thread(write_thread), .write_addr(write_addr),
        .write_data(write_data), .rden(rden), .read_addr(read_addr),
        .read_data(rd[2]), .read_valid(rv[2]), .read_thread(rt[2]),
        .ready(rdy[2]), .write_dropped(drop[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ec <= 0;
        else          ec <= ec + 1;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                     name, k, ec, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (rv[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid dut%0d cycle %0d: got 1 expected 0",
                             k, ec);
                end else begin
                    e = sbq[k].pop_front();
                    check("read_data", k, rd[k], e.data);
                    check("read_thread", k, rt[k], e.thr);
                    check("read_latency", k, ec, e.due);
                end
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 128; a++)
                mem[k][a] = 20'h00001;
    endtask

    task automatic cyc(input bit we, input logic [2:0] wt, input logic [3:0] wa,
                       input logic [19:0] wd, input bit re, input logic [3:0] ra);
        bit   exp_drop [N];
        bit   run;
        bit   ok;
        int   thr;
        exp_t e;
        wren         = we;
        write_thread = wt;
        write_addr   = wa;
        write_data   = wd;
        rden         = re;
        read_addr    = ra;
        for (int k = 0; k < N; k++) begin
            run = (ec >= dep_of(k));
            ok  = (int'(wt) < tc_of(k));
            if (re && run) begin
                thr    = ec % tc_of(k);
                e.data = (we && ok && int'(wt) == thr && wa == ra && new_of(k))
                         ? wd : mem[k][thr * 16 + int'(ra)];
                e.thr  = 3'(thr);
                e.due  = ec + lat_of(k);
                sbq[k].push_back(e);
            end
            if (we && run && ok)
                mem[k][int'(wt) * 16 + int'(wa)] = wd;
            exp_drop[k] = we && !(run && ok);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            check("write_dropped", k, 32'(drop[k]), 32'(exp_drop[k]));
            check("ready", k, 32'(rdy[k]), 32'(ec >= dep_of(k)));
        end
        @(negedge clock);
        wren = 1'b0;
        rden = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b0, 4'd0);
    endtask

    task automatic wait_thread(input int t);
        int guard = 0;
        while ((ec % 8) != t && guard < 16) begin
            idle(1);
            guard++;
        end
        if (guard >= 16) begin
            total++;
            bad++;
            $display("FAIL wait_thread: got %0d expected %0d", ec % 8, t);
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_read_data", k, rd[k], 0);
            check("rst_read_valid", k, 32'(rv[k]), 0);
            check("rst_read_thread", k, rt[k], 0);
            check("rst_ready", k, 32'(rdy[k]), 0);
            check("rst_write_dropped", k, 32'(drop[k]), 0);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n      = 1'b1;
        wren         = 1'b0;
        write_thread = '0;
        write_addr   = '0;
        write_data   = '0;
        rden         = 1'b0;
        read_addr    = '0;
        model_reset();
        @(negedge clock);
        do_reset();
        idle(3);
        cyc(1'b1, 3'd2, 4'd9, 20'hFFFFF, 1'b1, 4'd9);
        idle(45);
        do_reset();
        cyc(1'b1, 3'd2, 4'd9, 20'hFFFFF, 1'b0, 4'd0);
        idle(130);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd0);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'hF);
        wait_thread(0);
        cyc(1'b1, 3'd3, 4'd5, 20'hABCDE, 1'b0, 4'd0);
        wait_thread(3);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd5);
        wait_thread(2);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd5);
        wait_thread(3);
        cyc(1'b1, 3'd3, 4'd5, 20'h12345, 1'b1, 4'd5);
        wait_thread(3);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd5);
        cyc(1'b1, 3'd7, 4'd1, 20'h55555, 1'b0, 4'd0);
        wait_thread(7);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd1);
        wait_thread(2);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd9);
        wait_thread(4);
        cyc(1'b1, 3'd3, 4'd6, 20'h0AAAA, 1'b1, 4'd6);
        wait_thread(0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'(i));
        wait_thread(3);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd6);
        idle(4);
        do_reset();
        idle(130);
        wait_thread(3);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd5);
        wait_thread(7);
        cyc(1'b0, 3'd0, 4'd0, 20'h0, 1'b1, 4'd1);
        idle(4);
        for (int k = 0; k < N; k++)
            check("scoreboard_empty", k, sbq[k].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_memory_mt.md
Name: control_memory_mt

Overview:
- Multithreaded opcode-to-control-word translation RAM; next generation of the per-thread Control Memory.
- Adds: explicit write-thread addressing; self-initialisation to a default (NOP) word after reset, so no init file is needed; configurable read latency; read/write collision forwarding; thread-tagged read output with a valid flag.
- Sits between instruction decode (opcode) and the ALU control input.

Parameters:
OPCODE_WIDTH, 4, opcode / per-thread address width
CONTROL_WIDTH, 20, control word width
THREAD_COUNT, 8, hardware threads, >= 2, need not be a power of 2
THREAD_COUNT_WIDTH, 3, clog2(THREAD_COUNT)
READ_LATENCY, 1, rden-to-read_data cycles, legal values 1 or 2
READ_NEW_DATA, 0, 1 = same-cycle read of the write address returns write_data; 0 = returns old data
DEFAULT_CONTROL, 0, word written to every entry during init
RAMSTYLE, "", synthesis RAM style attribute

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
wren  in  1  write enable, accepted only when ready=1
write_thread  in  THREAD_COUNT_WIDTH  thread whose table is written
write_addr  in  OPCODE_WIDTH  opcode entry to write
write_data  in  CONTROL_WIDTH  control word to write
rden  in  1  read enable
read_addr  in  OPCODE_WIDTH  opcode of the current thread
read_data  out  CONTROL_WIDTH  control word
read_valid  out  1  read_data holds the result of a rden issued READ_LATENCY cycles earlier
read_thread  out  THREAD_COUNT_WIDTH  thread that issued the read, aligned with read_data
ready  out  1  initialisation complete
write_dropped  out  1  one-cycle pulse when a write was ignored

Behaviour:
- Reset (async assert, sync release): FSM=INIT, init_addr=0, current_thread=0, ready=0, read_data=0, read_valid=0, read_thread=0, write_dropped=0, read pipeline cleared.
- Thread counter: current_thread increments every cycle and wraps THREAD_COUNT-1 -> 0. It runs in both INIT and RUN.
- RAM depth is CM_DEPTH = THREAD_COUNT * 2^OPCODE_WIDTH. Address = {thread, opcode}, with the thread in the MSBs.
- FSM INIT:
  - Each cycle, write DEFAULT_CONTROL at init_addr, then increment init_addr.
  - After the write to CM_DEPTH-1, go to RUN; ready=1 from the next cycle.
  - INIT therefore lasts exactly CM_DEPTH cycles after reset release.
  - External wren during INIT is ignored and pulses write_dropped the following cycle.
  - rden during INIT is ignored: read_valid stays 0 and read_data stays 0.
- FSM RUN:
  - RUN is terminal; only reset returns the FSM to INIT.
  - Write: on wren, store write_data at {write_thread, write_addr}.
  - If write_thread >= THREAD_COUNT, the write is suppressed and write_dropped pulses the next cycle.
  - Read: on rden, the read address is {current_thread, read_addr}. current_thread is captured into the tag pipeline.
  - READ_LATENCY=1: data, valid and tag appear on the next edge.
  - READ_LATENCY=2: an extra output register stage is added.
  - When rden=0, read_data holds its last value and read_valid=0.
  - Collision (wren and rden in the same cycle, same full address): READ_NEW_DATA=1 returns write_data; READ_NEW_DATA=0 returns the prior content. The write always lands.
  - Writes to different addresses in the same cycle are independent.
- Reset asserted mid-INIT or mid-RUN: the state machine restarts full initialisation, and all prior RAM contents are treated as lost.
- Widths: init_addr is CM_ADDR_WIDTH+1 bits to detect the terminal count without wrap ambiguity.

Decomposition:
- Shared package control_memory_pkg:
  - localparams CM_ADDR_WIDTH = OPCODE_WIDTH + THREAD_COUNT_WIDTH and CM_DEPTH;
  - FSM state encoding (INIT=1'b0, RUN=1'b1);
  - legal READ_LATENCY check constants.
- One sub-module, control_memory_thread_counter: the wrapping thread counter with async active-low reset.
- The RAM is an inferred simple dual-port array inside the top level.

Test Plan:
- Release reset with THREAD_COUNT=8, OPCODE_WIDTH=4 -> ready rises exactly 128 cycles later. Any read then returns DEFAULT_CONTROL=20'h00001 with read_valid=1 one cycle after rden.
- wren with write_thread=3, write_addr=4'h5, write_data=20'hABCDE; rden when current_thread=3, read_addr=5 -> read_data=20'hABCDE, read_thread=3. The same opcode from thread 2 -> 20'h00001.
- Same-cycle write/read of {3,5} with new data 20'h12345: READ_NEW_DATA=1 -> 20'h12345; READ_NEW_DATA=0 -> 20'hABCDE, then 20'h12345 on the next thread-3 read.
- THREAD_COUNT=6, write_thread=7 -> write_dropped=1 for one cycle and no RAM entry changes. wren during INIT -> write_dropped=1, and the entry reads DEFAULT after ready.
- READ_LATENCY=2: rden at cycle t -> read_valid=1 at t+2 only, with read_thread equal to the thread at t. Back-to-back rden over 8 cycles -> thread tags 0..7 stream out in order.
- Assert reset_n=0 at cycle 50 of INIT and again during RUN after writes -> all outputs go to 0 immediately. Re-init takes 128 cycles, and all prior writes read back as DEFAULT_CONTROL.
